// File: rtl/r_format_sequencer_if.sv
// Instruction-memory request/response bundle between the sequencer (master) and IM (slave).
// imem_req/imem_addr stay asserted until imem_valid is seen; no other flow control.
interface r_format_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/r_format_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the R-format datapath: 4 cycles/instr + IM wait states.
// Stalls in FETCH until imem_valid; ILLEGAL_OP_TRAP_EN selects trap-and-halt vs NOP for nonzero opcodes.
module r_format_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  r_format_sequencer_if.master imem,
  output logic [31:0]          instr,
  output logic [1:0]           alu_op,
  output logic                 rf_reg_write,
  output logic [31:0]          pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_SKIP,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               trap_q, trap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    trap_d    = trap_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = RESET_PC;
          retired_d = '0;
          trap_d    = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem.imem_valid) begin
          instr_d = imem.imem_rdata;
          state_d = (imem.imem_rdata == HALT_WORD) ? S_HALT : S_DECODE;
        end
      end
      S_DECODE: begin
        if (instr_q[31:26] == 6'b000000) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
          trap_d  = 1'b1;
          state_d = S_HALT;
`else
          state_d = S_SKIP;
`endif
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        // pc wraps naturally at 2^32; retired holds at all-ones
        pc_d      = pc_q + 32'd4;
        retired_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + 1'b1;
        state_d   = stop ? S_HALT : S_FETCH;
      end
      S_SKIP: begin
        pc_d    = pc_q + 32'd4;
        state_d = stop ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state_q so an async reset kills them at once.
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign alu_op         = (state_q == S_EXEC || state_q == S_WB) ? 2'b10 : 2'b00;
  assign rf_reg_write   = (state_q == S_WB) && (instr_q[15:11] != 5'd0);
  assign pc             = pc_q;
  assign busy           = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted         = (state_q == S_HALT);
  assign trap           = trap_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_r_format_sequencer.sv
// Randomized program/wait-state bench for r_format_sequencer against a per-instruction reference model.
module tb_r_format_sequencer;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] instr, pc;
  logic [1:0]  alu_op;
  logic        rf_reg_write, busy, halted, trap;
  logic [15:0] retired;

  r_format_sequencer_if bus ();

  r_format_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .imem         (bus),
    .instr        (instr),
    .alu_op       (alu_op),
    .rf_reg_write (rf_reg_write),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .trap         (trap),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  logic [31:0] mem [0:31];
  int          waits [0:63];
  int          fidx = 0;
  int          wcnt = 0;
  int          stop_idx = 99;
  bit          mon_en = 1'b0;
  bit          prev_wr = 1'b0;
  logic [31:0] exp_wr [$];

  // IM responder: valid after waits[fidx] stall cycles of each request
  always @(negedge clk) begin
    if (bus.imem_req && wcnt >= waits[fidx % 64]) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = mem[bus.imem_addr[6:2]];
    end else begin
      bus.imem_valid = 1'b0;
      bus.imem_rdata = $urandom;
    end
    if (mon_en && bus.imem_req && fidx == stop_idx) stop = 1'b1;
    if (mon_en) begin
      if (rf_reg_write) begin
        check("wb_alu_op", alu_op, 2'b10);
        check("rf_back_to_back", prev_wr, 0);
        if (exp_wr.size() == 0) check("rf_extra_write", 1, 0);
        else check("rf_write_instr", instr, exp_wr.pop_front());
      end
      prev_wr = rf_reg_write;
    end
  end

  always @(posedge clk) begin
    if (bus.imem_req && bus.imem_valid) begin
      fidx++;
      wcnt = 0;
    end else if (bus.imem_req) begin
      wcnt++;
    end
  end

  function automatic logic [31:0] r_word(input bit zero_rd);
    logic [4:0] rd;
    rd = zero_rd ? 5'd0 : 5'($urandom_range(1, 31));
    return {6'b0, 5'($urandom), 5'($urandom), rd, 5'($urandom), 6'($urandom)};
  endfunction

  task automatic clear_prog(input int w);
    for (int i = 0; i < 32; i++) mem[i] = HALT_WORD;
    for (int i = 0; i < 64; i++) waits[i] = w;
    stop_idx = 99;
  endtask

  task automatic gen_random();
    int len, k;
    logic [31:0] w;
    bit zw;
    len = $urandom_range(1, 16);
    zw  = ($urandom_range(0, 3) == 0);
    clear_prog(0);
    for (int i = 0; i < 64; i++) waits[i] = zw ? 0 : $urandom_range(0, 3);
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin
        w = r_word(k == 5);
      end else if (k <= 8) begin
        w = {6'($urandom_range(1, 63)), 26'($urandom)};
        if (w == HALT_WORD) w[0] = 1'b0;
      end else begin
        w = HALT_WORD;
      end
      mem[i] = w;
    end
    stop_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : 99;
  endtask

  // Walk the program instruction by instruction and predict the final architectural state.
  task automatic run_prog(input string nm);
    logic [31:0] m_pc, m_instr, w;
    int          m_ret, m_cyc, fi, cyc;
    bit          m_trap;
    m_pc = 32'h0; m_ret = 0; m_cyc = 0; fi = 0; m_trap = 1'b0; m_instr = 32'h0;
    exp_wr.delete();
    while (1) begin
      w = mem[m_pc[6:2]];
      m_instr = w;
      m_cyc += waits[fi];
      if (w == HALT_WORD) begin
        m_cyc += 1;
        break;
      end
      if (w[31:26] == 6'd0) begin
        m_cyc += 4;
        if (w[15:11] != 5'd0) exp_wr.push_back(w);
        m_pc += 4;
        m_ret++;
      end else begin
`ifdef ILLEGAL_OP_TRAP_EN
        m_cyc += 2;
        m_trap = 1'b1;
        break;
`else
        m_cyc += 3;
        m_pc += 4;
`endif
      end
      if (fi == stop_idx) break;
      fi++;
    end

    fidx = 0; wcnt = 0; stop = 1'b0; prev_wr = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({nm, ":start_pc"}, pc, 0);
    check({nm, ":start_retired"}, retired, 0);
    check({nm, ":start_trap"}, trap, 0);
    check({nm, ":start_busy"}, busy, 1);
    cyc = 0;
    while (!halted && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
      if (!halted) start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check({nm, ":cycles"}, cyc, m_cyc);
    check({nm, ":halted"}, halted, 1);
    check({nm, ":busy"}, busy, 0);
    check({nm, ":pc"}, pc, m_pc);
    check({nm, ":retired"}, retired, m_ret);
    check({nm, ":trap"}, trap, m_trap);
    check({nm, ":instr"}, instr, m_instr);
    check({nm, ":missing_writes"}, exp_wr.size(), 0);
    @(negedge clk);
    mon_en = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    bit seen;
    clear_prog(0);
    #1;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
    check("rst_retired", retired, 0);
    check("rst_trap", trap, 0);
    check("rst_rf_write", rf_reg_write, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_imem_req", bus.imem_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stop  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_stop_busy", busy, 0);
    check("idle_stop_halted", halted, 0);
    stop = 1'b0;

    // add $3,$1,$2 then halt, zero-wait
    clear_prog(0);
    mem[0] = 32'h0022_1820;
    run_prog("single_add");

    clear_prog(3);
    mem[0] = r_word(1'b0);
    mem[1] = r_word(1'b0);
    run_prog("wait3");

    clear_prog(0);
    mem[0] = 32'h0022_0020;
    run_prog("rd_zero");

    clear_prog(0);
    mem[0] = r_word(1'b0);
    mem[1] = r_word(1'b0);
    mem[2] = 32'h8C22_0000;
    run_prog("illegal_op");

    clear_prog(1);
    for (int i = 0; i < 4; i++) mem[i] = r_word(1'b0);
    stop_idx = 1;
    run_prog("stop_second");

    // async reset landing in EXEC
    clear_prog(0);
    mem[0] = 32'h0022_1820;
    fidx = 0; wcnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (alu_op == 2'b10 && !rf_reg_write) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("rst_exec_reached", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rf_write", rf_reg_write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_pc", pc, 0);
    check("midrst_instr", instr, 0);
    @(posedge clk);
    #1;
    check("midrst_rf_write_next", rf_reg_write, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_busy", busy, 0);
    check("postrst_halted", halted, 0);
    check("postrst_pc", pc, 0);

    for (int r = 0; r < 40; r++) begin
      gen_random();
      run_prog($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
